// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with a registered result.
// Logic and arithmetic ops finish in one cycle. Shifts by a non-zero
// amount run one bit per cycle and hold Busy until they finish.
//
// Handshake: Start is sampled on a rising edge only while Busy is low, and
// each accepted request completes with exactly one single-cycle Done pulse.
// Result and Zero update on that same edge and hold until the next
// completion. Start seen while Busy is high is dropped. The Busy output is
// the FSM state (high means SHIFT), so the state can be observed directly.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [1:0] M_SLL = 2'd0;
  localparam logic [1:0] M_SRL = 2'd1;
  localparam logic [1:0] M_SRA = 2'd2;

  logic [0:0]         state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] count;
  logic [1:0]         mode;

  logic [WIDTH-1:0]   quick;
  logic               is_shift;
  logic [1:0]         req_mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   step;

  // Only the low shift-amount bits of B count; upper bits are ignored.
  assign shamt = B[SHAMT_W-1:0];
  assign Busy  = (state == SHIFT);

  // One-cycle result for the current request. A shift by zero returns A.
  always_comb begin
    quick    = '0;
    is_shift = 1'b0;
    req_mode = M_SLL;
    case (Operation)
      OP_AND: quick = A & B;
      OP_OR:  quick = A | B;
      OP_ADD: quick = A + B;
      OP_SUB: quick = A - B;
      OP_SLT: quick = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_XOR: quick = A ^ B;
      OP_SLL: begin quick = A; is_shift = 1'b1; req_mode = M_SLL; end
      OP_SRL: begin quick = A; is_shift = 1'b1; req_mode = M_SRL; end
      OP_SRA: begin quick = A; is_shift = 1'b1; req_mode = M_SRA; end
      default: quick = '0;
    endcase
  end

  // One-bit shift of the working register in the latched direction.
  always_comb begin
    step = work << 1;
    case (mode)
      M_SRL:   step = work >> 1;
      M_SRA:   step = {work[WIDTH-1], work[WIDTH-1:1]};
      default: step = work << 1;
    endcase
  end

  // FSM, shift datapath and the registered Result/Zero/Done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      mode   <= M_SLL;
      Result <= '0;
      Zero   <= 1'b1;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (is_shift && (shamt != '0)) begin
              work  <= A;
              count <= shamt;
              mode  <= req_mode;
              state <= SHIFT;
            end else begin
              Result <= quick;
              Zero   <= (quick == '0);
              Done   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work  <= step;
          count <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            Result <= step;
            Zero   <= (step == '0);
            Done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized bench for alu_exec_unit against an arithmetic model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  Operation;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        Zero;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Operation(Operation),
    .A(A), .B(B), .Result(Result), .Zero(Zero), .Busy(Busy), .Done(Done)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Reference model: result straight from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return a ^ b;
      4'b0011: return a << sh;
      4'b1000: return a >> sh;
      4'b1001: return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Reference latency: cycles from accept to Done (0 means the next cycle).
  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'b0011 || op == 4'b1000 || op == 4'b1001) return int'(b % 32);
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to completion. With poke set, random
  // Start pulses and operand changes are thrown at the unit while it is busy.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    logic [31:0] exp;
    int k;
    exp = ref_alu(op, a, b);
    k   = ref_lat(op, b);
    @(negedge clk);
    Start = 1'b1; Operation = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0;
    if (k == 0) begin
      chk("done_1cyc", 32'(Done), 32'd1);
      chk("busy_1cyc", 32'(Busy), 32'd0);
      chk("result_1cyc", Result, exp);
      chk("zero_1cyc", 32'(Zero), 32'(exp == 0));
    end else begin
      chk("busy_start", 32'(Busy), 32'd1);
      chk("done_start", 32'(Done), 32'd0);
      for (int i = 1; i < k; i++) begin
        @(negedge clk);
        if (poke) begin
          Start = 1'($urandom_range(0, 1)); Operation = 4'($urandom);
          A = $urandom; B = $urandom;
        end
        @(posedge clk); #1;
        Start = 1'b0;
        chk("busy_shift", 32'(Busy), 32'd1);
        chk("done_shift", 32'(Done), 32'd0);
      end
      @(negedge clk);
      if (poke) begin Start = 1'b1; Operation = 4'b0010; A = $urandom; end
      @(posedge clk); #1;
      Start = 1'b0;
      chk("done_shift_end", 32'(Done), 32'd1);
      chk("busy_shift_end", 32'(Busy), 32'd0);
      chk("result_shift", Result, exp);
      chk("zero_shift", 32'(Zero), 32'(exp == 0));
    end
    @(posedge clk); #1;
    chk("done_after", 32'(Done), 32'd0);
    chk("result_hold", Result, exp);
  endtask

  logic [3:0]  op_tab [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                               4'b1100, 4'b0011, 4'b1000, 4'b1001, 4'b1111};
  logic [3:0]  b2b_op [4]  = '{4'b0010, 4'b0001, 4'b0000, 4'b1100};
  logic [31:0] exp_q[$];

  initial begin
    int done_seen;
    logic [31:0] last;
    reset = 1'b1; Start = 1'b0; Operation = 4'b0000; A = '0; B = '0;

    // Reset values.
    #2;
    chk("rst_result", Result, 32'd0);
    chk("rst_zero", 32'(Zero), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_done", 32'(Done), 32'd0);

    // Directed single-cycle ops.
    do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(4'b0110, 32'd5, 32'd7, 1'b0);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(4'b1100, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0);
    do_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    // Asynchronous reset mid-cycle while a nonzero Result is held.
    do_op(4'b0001, 32'h00FF_0000, 32'h0000_00FF, 1'b0);
    #3; reset = 1'b1; #1;
    chk("arst_result", Result, 32'd0);
    chk("arst_zero", 32'(Zero), 32'd1);
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_done", 32'(Done), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Iterative shifts and shift-amount edge cases.
    do_op(4'b1001, 32'h8000_0000, 32'd4, 1'b1);
    do_op(4'b0011, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_op(4'b1000, 32'h8000_0000, 32'd31, 1'b0);
    do_op(4'b1000, 32'h8000_0000, 32'h21, 1'b0);
    do_op(4'b0011, 32'h8000_0001, 32'd1, 1'b1);

    // Back-to-back one-cycle ops with Start held high.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      exp_q.push_back(ref_alu(b2b_op[i], a, b));
      @(negedge clk);
      Start = 1'b1; Operation = b2b_op[i]; A = a; B = b;
      @(posedge clk); #1;
      chk("b2b_done", 32'(Done), 32'd1);
      last = exp_q.pop_front();
      chk("b2b_result", Result, last);
    end
    @(negedge clk); Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("b2b_idle_done", 32'(Done), 32'd0);
      chk("b2b_hold", Result, last);
    end

    // Reset in the middle of a long shift: the request must never complete.
    @(negedge clk);
    Start = 1'b1; Operation = 4'b0011; A = 32'h0000_0ABC; B = 32'd20;
    @(posedge clk); #1; Start = 1'b0;
    repeat (4) @(posedge clk);
    #3; reset = 1'b1; #1;
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_result", Result, 32'd0);
    @(negedge clk); reset = 1'b0;
    done_seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (Done) done_seen++;
    end
    chk("mid_rst_no_done", 32'(done_seen), 32'd0);
    chk("mid_rst_idle", 32'(Busy), 32'd0);
    do_op(4'b0010, 32'd2, 32'd3, 1'b0);

    // Randomized requests against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] b;
      logic [3:0] op;
      op = op_tab[$urandom_range(0, 9)];
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
      do_op(op, $urandom, b, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic unit that consumes the 4-bit `Operation` code produced by the ALU controller, together with two operands, and returns a registered result under a start/done handshake. AND/OR/ADD/SUB/SLT/XOR complete in one cycle. Shifts, on extension codes the controller will issue once shift decode is added, run iteratively at one bit per cycle. The block sits between the ALU controller/register-file read and the writeback/PMP address path, and lets the core stall on `Busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `SHAMT_W`, 5, shift-amount width (log2 WIDTH)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `Start`  in  1  request; sampled on a rising edge only when not `Busy`
- `Operation`  in  4  ALU control code
- `A`  in  WIDTH  operand 1 (shift source)
- `B`  in  WIDTH  operand 2 (shift amount = `B[SHAMT_W-1:0]`)
- `Result`  out  WIDTH  registered result; holds until next completion
- `Zero`  out  1  registered, equals (`Result` == 0)
- `Busy`  out  1  high while an iterative shift is in progress
- `Done`  out  1  one-cycle pulse marking a new valid `Result`

## Operation
Operation codes:
- 0000 AND
- 0001 OR
- 0010 ADD, wraps mod 2^WIDTH
- 0110 SUB, A−B mod 2^WIDTH
- 0111 SLT, signed; `Result` = {WIDTH-1 zeros, A<B}
- 1100 XOR
- 0011 SLL
- 1000 SRL
- 1001 SRA, sign-filled
- any other code → `Result`=0, completes in one cycle

State machine, states IDLE and SHIFT:
- IDLE, `Start`=1, non-shift code, or shift code with shamt=0: `Result` is computed and registered (shamt=0 gives `Result`=A), `Done`=1, state stays IDLE.
- IDLE, `Start`=1, shift code with shamt=k>0: working register←A, counter←k, direction/arith flag latched, go to SHIFT.
- SHIFT, each edge: working register shifts 1 bit and the counter decrements. On the edge where the counter goes 1→0: `Result`←shifted value, `Done`=1, return to IDLE.
- `Start` while `Busy` is ignored. Operands and code are not re-sampled during SHIFT; the latched copies are used.
- `Busy` = (state==SHIFT), registered.
- `Zero` is updated on the same edge as `Result`.

## Timing
- Reset, asynchronous: state=IDLE, `Result`=0, `Zero`=1, `Busy`=0, `Done`=0, counter=0.
- `Start` sampled at edge N, one-cycle op: `Result`/`Zero`/`Done` valid in the cycle after edge N.
- Shift with k>0: `Busy`=1 after edge N. `Result`, `Done`=1 and `Busy`=0 follow edge N+k. Latency is k cycles to `Done`, and the unit is idle for a new `Start` at edge N+k+1.
- `Done` is high exactly one cycle per accepted request. `Done` stays 0 when `Start`=0 in IDLE.
- Back-to-back one-cycle ops: `Start` held high for consecutive edges produces a `Done` every cycle.
- Shift completion and the next accept cannot overlap, because `Start` on the completion edge is ignored (state is still SHIFT at that edge).
- `reset` asserted mid-SHIFT: immediate return to IDLE with reset values, and the aborted request never produces `Done`.
- Shamt uses only the low `SHAMT_W` bits of `B`. Upper bits are ignored (B=33 shifts by 1).

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → `Result`=0, `Zero`=1, `Busy`=0, `Done`=0 immediately.
- Single-cycle ops: A=0xFFFF_FFFF, B=1. Code 0010 → `Result`=0, `Zero`=1, `Done` one cycle. Code 0110 with A=5, B=7 → 0xFFFF_FFFE. Code 0111 with A=−1, B=1 → 1. Code 1100 with A=0xF0F0_F0F0, B=0xFFFF_FFFF → 0x0F0F_0F0F. Code 1111 → 0.
- Iterative shift: code 1001, A=0x8000_0000, B=4 → `Busy` high 4 cycles, `Done` after edge N+4, `Result`=0xF800_0000. `Start` pulses during `Busy` are ignored.
- Shift edges: code 0011, B=0 → one-cycle `Result`=A. Code 1000, B=31, A=0x8000_0000 → `Result`=1 after 31 cycles. B=0x21 → shift by 1.
- Back-to-back: four consecutive `Start` edges with ADD/OR/AND/XOR → four consecutive `Done` pulses with matching results. `Result` then holds while `Start`=0.
- Reset mid-shift: SLL by 20, `reset` at cycle 5 → IDLE, no `Done`. A new ADD 2+3 afterwards → `Result`=5.
